mmu_result_accumulator: RTL

Downstream stage of the systolic matrix multiply unit. It takes the diagonally skewed `result_data` columns, de-skews them into one aligned row, and accumulates or overwrites that row into a flop-based accumulator buffer. The buffer has an independent registered read port for the activation/writeback stage.

---
 rtl/vTPU_pkg.sv | 14 +
 rtl/column_delay_line.sv | 43 ++++
 rtl/mmu_result_accumulator.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vTPU_pkg.sv
// rtl/vTPU_pkg.sv - shared word and accumulator address types for the vTPU datapath
//
// Purpose: common types used by the matrix multiply unit and its downstream stages.
//   WORD_WIDTH / WORD_TYPE : 32-bit two's complement datapath word
//   ACC_ADDRESS_TYPE       : accumulator row address, sized for the default 32-row buffer
package vTPU_pkg;

  localparam int WORD_WIDTH = 32;
  typedef logic [WORD_WIDTH-1:0] WORD_TYPE;

  localparam int ACC_DEPTH_DEFAULT = 32;
  typedef logic [$clog2(ACC_DEPTH_DEFAULT)-1:0] ACC_ADDRESS_TYPE;

endpackage

// File: rtl/column_delay_line.sv
// rtl/column_delay_line.sv - enable-gated shift register with synchronous reset
//
// Purpose: delays a WIDTH-bit value by DEPTH enabled cycles. DEPTH=0 is a plain wire.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset, clears every stage
//   enable in  stages shift only when high, otherwise they hold
//   din    in  value entering the line
//   dout   out value leaving the line (oldest stage)
module column_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Zero-depth line: clock and controls are intentionally unused.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, enable};
      assign dout = din;
    end else begin : g_regs
      logic [WIDTH-1:0] stage [0:DEPTH-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (enable) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mmu_result_accumulator.sv
// rtl/mmu_result_accumulator.sv - de-skews systolic result columns and accumulates rows
//
// Purpose: realigns the diagonally skewed multiply-unit output into one row, then
// overwrites or accumulates it into a flop-based accumulator buffer. A separate
// registered read port serves the activation/writeback stage.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   enable            advances the de-skew pipeline (shared with the multiply unit)
//   result_data       skewed columns; column i lags column 0 by i enabled cycles
//   result_valid      column 0 of a row is present this enabled cycle
//   result_address    destination row, sampled with result_valid
//   result_accumulate 1 = add into stored row, 0 = overwrite
//   read_enable       read request
//   read_address      row to read
//   read_data         registered row read (holds when no request)
//   read_valid        read_enable delayed one cycle
//   busy              a row is still travelling through the de-skew pipeline
module mmu_result_accumulator
  import vTPU_pkg::*;
#(
  parameter int MATRIX_WIDTH   = 14,
  parameter int ACC_DEPTH      = 32,
  parameter int ACC_ADDR_WIDTH = $clog2(ACC_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  WORD_TYPE                  result_data [0:MATRIX_WIDTH-1],
  input  logic                      result_valid,
  input  logic [ACC_ADDR_WIDTH-1:0] result_address,
  input  logic                      result_accumulate,
  input  logic                      read_enable,
  input  logic [ACC_ADDR_WIDTH-1:0] read_address,
  output WORD_TYPE                  read_data [0:MATRIX_WIDTH-1],
  output logic                      read_valid,
  output logic                      busy
);

  localparam int SB_WIDTH = ACC_ADDR_WIDTH + 2;
  localparam int CNT_W    = $clog2(MATRIX_WIDTH) + 1;

  WORD_TYPE                  row [0:MATRIX_WIDTH-1];
  logic [SB_WIDTH-1:0]       sb_in;
  logic [SB_WIDTH-1:0]       sb_out;
  logic                      wr_valid;
  logic [ACC_ADDR_WIDTH-1:0] wr_addr;
  logic                      wr_accum;
  WORD_TYPE                  acc [0:ACC_DEPTH-1][0:MATRIX_WIDTH-1];
  logic [CNT_W-1:0]          inflight;
  logic                      enter;
  logic                      leave;

  // Column c waits for the last column to arrive: MATRIX_WIDTH-1-c stages.
  generate
    for (genvar c = 0; c < MATRIX_WIDTH; c++) begin : g_col
      column_delay_line #(
        .DEPTH(MATRIX_WIDTH - 1 - c),
        .WIDTH(WORD_WIDTH)
      ) u_col (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .din   (result_data[c]),
        .dout  (row[c])
      );
    end
  endgenerate

  assign sb_in = {result_valid, result_address, result_accumulate};

  column_delay_line #(
    .DEPTH(MATRIX_WIDTH - 1),
    .WIDTH(SB_WIDTH)
  ) u_sideband (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .din   (sb_in),
    .dout  (sb_out)
  );

  assign {wr_valid, wr_addr, wr_accum} = sb_out;

  // Counting valids entering and leaving the sideband line is equivalent to
  // OR-ing its valid bits: nonzero exactly when some stage holds a valid row.
  assign enter = enable && result_valid;
  assign leave = enable && wr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (enter && !leave) begin
      inflight <= inflight + CNT_W'(1);
    end else if (leave && !enter) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  assign busy = (inflight != '0);

  // Single-cycle read-modify-write on the flop array; the read port samples
  // the pre-write contents because both use the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < ACC_DEPTH; a++)
        for (int c = 0; c < MATRIX_WIDTH; c++) acc[a][c] <= '0;
      for (int c = 0; c < MATRIX_WIDTH; c++) read_data[c] <= '0;
      read_valid <= 1'b0;
    end else begin
      if (enable && wr_valid) begin
        for (int c = 0; c < MATRIX_WIDTH; c++)
          acc[wr_addr][c] <= wr_accum ? acc[wr_addr][c] + row[c] : row[c];
      end
      read_valid <= read_enable;
      if (read_enable) begin
        for (int c = 0; c < MATRIX_WIDTH; c++) read_data[c] <= acc[read_address][c];
      end
    end
  end

endmodule
